// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions.
// funct3 size codes and LSU state encoding.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT_R,
    LSU_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane
// extraction/extension for loads.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  output logic [31:0] rdata_ext
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  // size decode: lanes, replication, alignment, extension
  always_comb begin
    be         = '0;
    wdata_lane = '0;
    misalign   = 1'b0;
    rdata_ext  = '0;
    unique case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = funct3[2] ? {24'b0, b}
                               : {{24{b[7]}}, b};
      end
      2'b01: begin
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
        misalign   = off[0];
        rdata_ext  = funct3[2] ? {16'b0, h}
                               : {{16{h[15]}}, h};
      end
      2'b10: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        misalign   = |off;
        rdata_ext  = rdata;
      end
      default: begin
        be = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access engine driving
// a valid/ready bus; feeds writeback source 2.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  lsu_state_e state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [31:0]       wd_q;
  logic [7:0]        cnt;

  logic        in_idle, in_req, in_wait;
  logic        accept, bad_f3, misalign;
  logic        illegal, timeout;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wl, al_ld;

  assign in_idle = state == LSU_IDLE;
  assign in_req  = state == LSU_REQ;
  assign in_wait = state == LSU_WAIT_R;
  assign accept  = in_idle & req_valid;

  // IDLE checks the live request; later states use the latch
  assign al_f3  = in_idle ? req_funct3 : f3_q;
  assign al_off = in_idle ? req_addr[1:0] : addr_q[1:0];

  lsu_lane_align u_align (
    .funct3     (al_f3),
    .off        (al_off),
    .wdata      (wd_q),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_lane (al_wl),
    .misalign   (misalign),
    .rdata_ext  (al_ld)
  );

  assign bad_f3 = (req_funct3 == 3'b011)
                | (req_funct3[2:1] == 2'b11)
                | (req_write & req_funct3[2]);
  assign illegal = bad_f3 | misalign;
  assign timeout = (cnt + 8'd1) == TO;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      LSU_IDLE: begin
        if (req_valid)
          state_n = illegal ? LSU_DONE : LSU_REQ;
      end
      LSU_REQ: begin
        if (mem_ready)
          state_n = we_q ? LSU_DONE : LSU_WAIT_R;
      end
      LSU_WAIT_R: begin
        if (mem_rvalid || timeout)
          state_n = LSU_DONE;
      end
      LSU_DONE: state_n = LSU_IDLE;
    endcase
  end

  // request latch, wait counter, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      load_data <= '0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        f3_q   <= req_funct3;
        we_q   <= req_write;
        wd_q   <= req_wdata;
      end
      if (accept && illegal)
        err <= 1'b1;
      if (in_req && mem_ready && we_q)
        err <= 1'b0;
      if (in_wait) begin
        cnt <= cnt + 8'd1;
        if (mem_rvalid) begin
          load_data <= al_ld;
          err       <= 1'b0;
        end else if (timeout) begin
          load_data <= '0;
          err       <= 1'b1;
        end
      end
      if (state == LSU_DONE)
        cnt <= '0;
    end
  end

  assign done      = state == LSU_DONE;
  assign stall     = req_valid & ~done;
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = in_req ? al_be : '0;
  assign mem_wdata = in_req ? al_wl : '0;

endmodule
